dmem_sram_bridge: RTL

- Memory-stage data-access bridge. Sits directly downstream of the pipelined datapath's M stage.
- Consumes the M-stage access: ALU address, store data and byte write enables.
- Drives a single-outstanding SRAM-like request/ack bus and returns the load word as readdataM.
- Raises a stall to the hazard unit while the access is in flight.

---
 rtl/dmem_sram_bridge_if.sv | 32 +++
 rtl/dmem_sram_bridge.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dmem_sram_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_sram_bridge_if
//  Description : SRAM-like single-outstanding request/ack bus between the
//                memory-stage bridge (master) and the data SRAM (slave).
//                Signal map to the bridge bus names:
//                  req=bus_req_o  wr=bus_wr_o  be=bus_be_o  addr=bus_addr_o
//                  wdata=bus_wdata_o  addr_ok=bus_addr_ok_i
//                  data_ok=bus_data_ok_i  rdata=bus_rdata_i
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_sram_bridge_if;
    logic        req;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, be, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, be, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_sram_bridge
//  Description : Memory-stage data-access bridge. Turns the M-stage access
//                into one transaction on an SRAM-like req/addr_ok/data_ok bus,
//                stalls the pipeline while it is in flight and returns the
//                full load word. Optional macro DMEM_PERF_CNT_EN adds stall
//                and access performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_sram_bridge #(
    parameter int          ADDR_MAP    = 1,
    parameter logic [31:0] RESET_RDATA = 32'h0000_0000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              mem_en_i,
    input  wire logic [3:0]        mem_wen_i,
    input  wire logic [31:0]       mem_addr_i,
    input  wire logic [31:0]       mem_wdata_i,
    output logic [31:0]            mem_rdata_o,
    output logic                   mem_stall_o,
    dmem_sram_bridge_if.master     bus
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]            perf_stall_cnt_o,
    output logic [31:0]            perf_acc_cnt_o
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        wr_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        capture;
    logic        launch;
    logic [31:0] mapped_addr;

    // A new access is only accepted from IDLE; later mem_en_i changes are ignored
    assign launch = (state_q == S_IDLE) && mem_en_i;

    // Next-state logic; capture marks the cycle the slave completes the data phase
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_en_i) state_d = S_REQ;
            end
            S_REQ: begin
                // data_ok without addr_ok cannot belong to this request
                if (bus.addr_ok) begin
                    if (bus.data_ok) begin
                        state_d = S_DONE;
                        capture = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus.data_ok) begin
                    state_d = S_DONE;
                    capture = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Latch the request fields once at launch so they stay stable on the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
        end else if (launch) begin
            wr_q    <= |mem_wen_i;
            be_q    <= (|mem_wen_i) ? mem_wen_i : 4'b1111;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
        end
    end

    // Load word register; only reads update it, so it holds between loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   rdata_q <= RESET_RDATA;
        else if (capture && !wr_q) rdata_q <= bus.rdata;
    end

    // Physical address: kseg0/kseg1 fold onto low memory, others pass through
    generate
        if (ADDR_MAP != 0) begin : g_addr_map
            always_comb begin
                mapped_addr = {addr_q[31:2], 2'b00};
                if (addr_q[31:29] == 3'b100 || addr_q[31:29] == 3'b101)
                    mapped_addr[31:29] = 3'b000;
            end
        end else begin : g_addr_pass
            assign mapped_addr = {addr_q[31:2], 2'b00};
        end
    endgenerate

    assign bus.req     = (state_q == S_REQ);
    assign bus.wr      = wr_q;
    assign bus.be      = be_q;
    assign bus.addr    = mapped_addr;
    assign bus.wdata   = wdata_q;
    assign mem_rdata_o = rdata_q;

    // DONE is the release cycle: the pipeline advances at its closing edge
    assign mem_stall_o = mem_en_i && (state_q != S_DONE);

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] acc_cnt_q;

    // Stall-cycle and completed-access counters, free-running with wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= 32'h0000_0000;
            acc_cnt_q   <= 32'h0000_0000;
        end else begin
            if (mem_stall_o)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (state_d == S_DONE && state_q != S_DONE)
                acc_cnt_q <= acc_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_acc_cnt_o   = acc_cnt_q;
`endif

endmodule
`default_nettype wire
